// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters.
// Fetch looks up the current PC combinationally and gets a predicted next PC.
// Execute writes resolved branch/JAL outcomes back, and this block also
// flags mispredictions, supplies the recovery PC and keeps saturating
// performance counters.
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [XLEN-1:0]      pc_f,
  output logic                 pred_taken_f,
  output logic [XLEN-1:0]      pred_next_pc_f,
  input  logic                 update_en_e,
  input  logic [XLEN-1:0]      pc_e,
  input  logic                 taken_e,
  input  logic [XLEN-1:0]      target_e,
  input  logic                 pred_taken_e,
  input  logic [XLEN-1:0]      pred_target_e,
  output logic                 mispredict_e,
  output logic [XLEN-1:0]      recover_pc_e,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;
  localparam logic [1:0] CTR_WEAK_T  = 2'b10;

  logic [ENTRIES-1:0] valid;
  logic [TAGW-1:0]    tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  logic [IDX-1:0]  idx_f;
  logic [TAGW-1:0] tag_f;
  logic [IDX-1:0]  idx_e;
  logic [TAGW-1:0] tag_e;
  logic            hit_f;
  logic            hit_e;

  // Byte-offset bits never take part in indexing or tagging.
  logic unused_pc_low;
  assign unused_pc_low = &{1'b0, pc_f[1:0], pc_e[1:0]};

  assign idx_f = pc_f[IDX+1:2];
  assign tag_f = pc_f[XLEN-1:IDX+2];
  assign idx_e = pc_e[IDX+1:2];
  assign tag_e = pc_e[XLEN-1:IDX+2];

  // Fetch-side lookup: redirect only on a valid tag hit whose counter leans taken.
  always_comb begin
    hit_f          = valid[idx_f] && (tag_mem[idx_f] == tag_f);
    pred_taken_f   = hit_f && ctr_mem[idx_f][1];
    pred_next_pc_f = pred_taken_f ? target_mem[idx_f] : (pc_f + PC_STEP);
  end

  // Execute-side check of the fetch guess and the PC to restart from.
  always_comb begin
    hit_e        = valid[idx_e] && (tag_mem[idx_e] == tag_e);
    mispredict_e = update_en_e &&
                   ((taken_e != pred_taken_e) ||
                    (taken_e && pred_taken_e && (target_e != pred_target_e)));
    recover_pc_e = taken_e ? target_e : (pc_e + PC_STEP);
  end

  // Table update: clear wins over a same-cycle update; taken misses allocate.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= CTR_WEAK_NT;
      end
    end else if (clear) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_mem[i] <= CTR_WEAK_NT;
      end
    end else if (update_en_e) begin
      if (hit_e) begin
        if (taken_e) begin
          if (ctr_mem[idx_e] != 2'b11) begin
            ctr_mem[idx_e] <= ctr_mem[idx_e] + 2'b01;
          end
          target_mem[idx_e] <= target_e;
        end else if (ctr_mem[idx_e] != 2'b00) begin
          ctr_mem[idx_e] <= ctr_mem[idx_e] - 2'b01;
        end
      end else if (taken_e) begin
        valid[idx_e]      <= 1'b1;
        tag_mem[idx_e]    <= tag_e;
        target_mem[idx_e] <= target_e;
        ctr_mem[idx_e]    <= CTR_WEAK_T;
      end
    end
  end

  // Saturating performance counters; they stick at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_en_e && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_WIDTH'(1);
      end
      if (mispredict_e && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
